// File: rtl/barrido_compuertas.sv
// Truth-table sweeper: drives 3-input vectors into a gate stage and captures its output into tabla.
// Define BARRIDO_COMPUERTAS_VERIF_EN to build the checker that compares each table with known gate tables.
module barrido_compuertas (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       inicio,
    input  logic       modo,
    input  logic [2:0] sel_ini,
    input  logic       sal,
    output logic       ent1,
    output logic       ent2,
    output logic       ent3,
    output logic [2:0] sel,
    output logic       act,
    output logic [7:0] tabla,
    output logic [2:0] tabla_sel,
    output logic       func_valida,
    output logic       ocupado,
    output logic       listo,
    output logic       error
);

    typedef enum logic [2:0] {REPOSO, APLICA, MUESTREA, ENTREGA, FIN} estado_t;

    estado_t    estado, estado_sig;
    logic [2:0] idx;
    logic [7:0] tabla_int;
    logic       modo_r;
    logic       otra_func;

    assign {ent3, ent2, ent1} = idx;
    assign otra_func = modo_r && (sel < 3'd6);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) estado <= REPOSO;
        else        estado <= estado_sig;
    end

    always_comb begin
        estado_sig  = estado;
        act         = 1'b0;
        ocupado     = 1'b1;
        func_valida = 1'b0;
        listo       = 1'b0;
        case (estado)
            REPOSO: begin
                ocupado = 1'b0;
                if (inicio) estado_sig = APLICA;
            end
            APLICA: begin
                act        = 1'b1;
                estado_sig = MUESTREA;
            end
            MUESTREA: begin
                act        = 1'b1;
                estado_sig = (idx == 3'd7) ? ENTREGA : APLICA;
            end
            ENTREGA: begin
                func_valida = 1'b1;
                estado_sig  = otra_func ? APLICA : FIN;
            end
            FIN: begin
                listo      = 1'b1;
                estado_sig = REPOSO;
            end
            default: estado_sig = REPOSO;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx       <= 3'd0;
            sel       <= 3'd0;
            modo_r    <= 1'b0;
            tabla_int <= 8'h00;
            tabla     <= 8'h00;
            tabla_sel <= 3'd0;
        end else begin
            case (estado)
                REPOSO: if (inicio) begin
                    idx    <= 3'd0;
                    modo_r <= modo;
                    sel    <= modo ? 3'd1 : sel_ini;
                end
                MUESTREA: begin
                    tabla_int[idx] <= sal;
                    // idx stops at 7 so it never wraps inside a function
                    if (idx != 3'd7) idx <= idx + 3'd1;
                end
                ENTREGA: begin
                    tabla     <= tabla_int;
                    tabla_sel <= sel;
                    if (otra_func) begin
                        sel <= sel + 3'd1;
                        idx <= 3'd0;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef BARRIDO_COMPUERTAS_VERIF_EN
    function automatic logic [7:0] tabla_esperada(input logic [2:0] s);
        case (s)
            3'd1:    return 8'h80;
            3'd2:    return 8'hFE;
            3'd3:    return 8'h96;
            3'd4:    return 8'h7F;
            3'd5:    return 8'h01;
            3'd6:    return 8'h69;
            default: return 8'h00;
        endcase
    endfunction

    // Sticky for the whole run; only a newly accepted start clears it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            error <= 1'b0;
        else if (estado == REPOSO && inicio)
            error <= 1'b0;
        else if (estado == ENTREGA && tabla_int != tabla_esperada(sel))
            error <= 1'b1;
    end
`else
    assign error = 1'b0;
`endif

endmodule
